// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter between the pipeline WB stage and a
// buffered multi-cycle-unit (MDU) result FIFO, with starvation forcing.
module wb_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_rd,
  input  logic [31:0] mdu_data,
  output logic        mdu_ready,
  output logic        pipe_stall,
  output logic        reg_write_enable,
  output logic [4:0]  reg_write_addr,
  output logic [31:0] reg_write_data
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, DRAIN, FORCE} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     rptr_q, rptr_d;
  logic [PW-1:0]     wptr_q, wptr_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [4:0]        rd_q   [DEPTH];
  logic [31:0]       data_q [DEPTH];

  logic head_live, head_wr, pipe_exec, blocked, pop, push, store;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    rptr_d           = rptr_q;
    wptr_d           = wptr_q;
    starve_d         = starve_q;
    vld_d            = vld_q;
    mdu_ready        = 1'b0;
    pipe_stall       = 1'b0;
    reg_write_enable = 1'b0;
    reg_write_addr   = '0;
    reg_write_data   = '0;
    head_wr          = 1'b0;
    pipe_exec        = 1'b0;
    blocked          = 1'b0;
    pop              = 1'b0;
    push             = 1'b0;
    store            = 1'b0;
    // Killed entries and rd=0 entries never claim the write port.
    head_live = (cnt_q != '0) && vld_q[rptr_q] && (rd_q[rptr_q] != 5'd0);

    if (rst_n) begin
      mdu_ready = (cnt_q < CW'(DEPTH));

      case (state_q)
        IDLE: pipe_exec = wb_valid;
        DRAIN: begin
          if (!head_live) begin
            pop       = (cnt_q != '0);
            pipe_exec = wb_valid;
          end else if (wb_valid) begin
            pipe_exec = 1'b1;
            blocked   = 1'b1;
          end else begin
            pop     = 1'b1;
            head_wr = 1'b1;
          end
        end
        FORCE: begin
          pop        = (cnt_q != '0);
          head_wr    = head_live;
          pipe_stall = 1'b1;
        end
        default: ;
      endcase

      if (pipe_exec && wb_rd != 5'd0) begin
        reg_write_enable = 1'b1;
        reg_write_addr   = wb_rd;
        reg_write_data   = wb_data;
      end
      if (head_wr) begin
        reg_write_enable = 1'b1;
        reg_write_addr   = rd_q[rptr_q];
        reg_write_data   = data_q[rptr_q];
      end

      // A pipeline write to r supersedes any older or same-cycle MDU result to r.
      push  = mdu_valid && mdu_ready;
      store = push && !(pipe_exec && mdu_rd == wb_rd);
      if (pipe_exec && wb_rd != 5'd0) begin
        for (int i = 0; i < DEPTH; i++)
          if (vld_q[i] && rd_q[i] == wb_rd) vld_d[i] = 1'b0;
      end

      if (pop) begin
        vld_d[rptr_q] = 1'b0;
        rptr_d        = inc(rptr_q);
      end
      if (store) begin
        vld_d[wptr_q] = 1'b1;
        wptr_d        = inc(wptr_q);
      end
      cnt_d = cnt_q + CW'(store) - CW'(pop);

      if (pop)                                           starve_d = '0;
      else if (blocked && starve_q < SW'(STARVE_MAX))    starve_d = starve_q + 1'b1;

      case (state_q)
        IDLE:    if (cnt_d != '0) state_d = DRAIN;
        DRAIN: begin
          if (cnt_d == '0)                     state_d = IDLE;
          else if (starve_d == SW'(STARVE_MAX)) state_d = FORCE;
        end
        FORCE:   state_d = (cnt_d != '0) ? DRAIN : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rptr_q   <= '0;
      wptr_q   <= '0;
      starve_q <= '0;
      vld_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rptr_q   <= rptr_d;
      wptr_q   <= wptr_d;
      starve_q <= starve_d;
      vld_q    <= vld_d;
    end
  end

  // Payload storage needs no reset; the valid bits qualify it.
  always_ff @(posedge clk) begin
    if (store) begin
      rd_q[wptr_q]   <= mdu_rd;
      data_q[wptr_q] <= mdu_data;
    end
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning the number of MDU result buffer entries (2..8).
REQ-002 SHALL have parameter STARVE_MAX, default 4, meaning the number of consecutive blocked cycles after which the buffer head is forced onto the write port.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 SHALL have port wb_valid, input, 1 bit: the pipeline writeback stage requests a register write this cycle.
REQ-006 SHALL have port wb_rd, input, 5 bits: the destination register of the pipeline write.
REQ-007 SHALL have port wb_data, input, 32 bits: the pipeline write data (already muxed among ALU, load and PC+4).
REQ-008 SHALL have port mdu_valid, input, 1 bit: the multi-cycle unit presents a completed result.
REQ-009 SHALL have port mdu_rd, input, 5 bits: the destination register of the MDU result.
REQ-010 SHALL have port mdu_data, input, 32 bits: the MDU result data.
REQ-011 SHALL have port mdu_ready, output, 1 bit: the arbiter accepts an MDU result this cycle.
REQ-012 SHALL have port pipe_stall, output, 1 bit: the pipeline must hold its WB stage contents this cycle.
REQ-013 SHALL have port reg_write_enable, output, 1 bit: the register-file write strobe.
REQ-014 SHALL have port reg_write_addr, output, 5 bits: the register-file write address.
REQ-015 SHALL have port reg_write_data, output, 32 bits: the register-file write data.

Function
REQ-016 SHALL accept an MDU result (push) when mdu_valid=1 and mdu_ready=1, with mdu_ready = (count < DEPTH) computed from registered state only, with no same-cycle pop pass-through.
REQ-017 SHALL store pushed entries in FIFO order with count ranging 0..DEPTH, read/write pointers wrapping modulo DEPTH, and simultaneous push and pop allowed at any count, including full.
REQ-018 SHALL NOT bypass the FIFO: an accepted MDU result reaches the write port no earlier than the cycle after acceptance.
REQ-019 SHALL implement FSM states IDLE (count=0), DRAIN (count>0, pipeline has priority) and FORCE (head forced, pipeline stalled).
REQ-020 SHALL in IDLE drive the port from the pipeline: enable=wb_valid, addr=wb_rd, data=wb_data, pipe_stall=0.
REQ-021 SHALL in DRAIN drive the pipeline write when wb_valid=1 and otherwise write the FIFO head and pop it, with pipe_stall=0.
REQ-022 SHALL in FORCE write the FIFO head, pop it, assert pipe_stall=1, and ignore wb_valid for that cycle.
REQ-023 SHALL keep starve_cnt, which increments each DRAIN cycle in which the head is blocked by wb_valid, clears on every pop, and saturates at STARVE_MAX.
REQ-024 SHALL make these transitions:
- IDLE->DRAIN on push.
- DRAIN->FORCE when starve_cnt reaches STARVE_MAX with the head still present.
- FORCE->DRAIN after one cycle if entries remain, otherwise FORCE->IDLE.
- DRAIN->IDLE when the last entry pops with no simultaneous push.
REQ-025 SHALL, on an executed pipeline write to register r, invalidate every valid FIFO entry with rd=r, and drop an incoming same-cycle push with rd=r, so the pipeline value wins.
REQ-026 SHALL make invalid entries occupy no write-port cycle: the head is popped silently (enable=0 for it) without waiting for the pipeline, and this counts as a pop.
REQ-027 SHALL NOT assert reg_write_enable for rd=0 from either source; such pipeline requests complete normally and such MDU entries are popped silently.
REQ-028 SHALL make reg_write_enable, reg_write_addr, reg_write_data, mdu_ready and pipe_stall combinational from the current state and inputs, so the register file writes at the same clock edge.

Reset
REQ-029 SHALL, when rst_n=0 at a rising edge, set the FSM to IDLE, count=0, both pointers=0, starve_cnt=0, and clear all entry valid bits.
REQ-030 SHALL, while rst_n=0, force reg_write_enable=0, reg_write_addr=0, reg_write_data=0, pipe_stall=0 and mdu_ready=0.
REQ-031 SHALL discard buffered MDU results if reset is asserted mid-operation, with no write occurring in the reset cycle.

Verification
REQ-032 SHALL pass pipeline-only: wb_valid=1, wb_rd=5, wb_data=0x1234 with the FIFO empty -> same cycle enable=1, addr=5, data=0x1234, pipe_stall=0.
REQ-033 SHALL pass MDU drain: push rd=7, data=0xDEAD at cycle 0 with wb_valid=0 -> cycle 1 enable=1, addr=7, data=0xDEAD, then IDLE.
REQ-034 SHALL pass starvation: push rd=3, then wb_valid=1 continuously with rd=9 -> 4 pipeline writes, then one cycle with pipe_stall=1 and addr=3, then pipeline writes resume.
REQ-035 SHALL pass full and wrap: with DEPTH=2, push 0xA to x1 and 0xB to x2 while wb_valid=1 -> mdu_ready=0; 8 further push/pop pairs -> order preserved and count never exceeds 2.
REQ-036 SHALL pass WAW kill: buffered entry rd=4, then pipeline write rd=4 with data 0x55 -> x4 written once with 0x55 and the FIFO entry popped silently.
REQ-037 SHALL pass reset mid-drain: 2 entries buffered, rst_n=0 for one edge -> all outputs 0, count=0, and no MDU write afterwards.
